noc_outport_arbiter: RTL and testbench
======================================

Name: noc_outport_arbiter

Overview:
- Per-output-port controller for the 5-port mesh router (E, W, S, N, PE input channels).
- Owns the router's even/odd phase (`polarity`).
- Arbitrates round-robin among input-channel head packets bound for this port, holding one output buffer per virtual channel (VC0 = even, VC1 = odd).
- Drives the downstream `so`/`ri` link handshake and the 64-bit outgoing packet; 5 instances sit inside each router between input buffers and neighbour links.

Parameters:
- DATA_W, 64, packet width in bits.
- N_REQ, 5, number of requesting input channels (index 0=E, 1=W, 2=S, 3=N, 4=PE).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-channel head-packet-valid, routed to this port.
- req_vc  in  N_REQ  VC bit of each channel's head packet.
- pkt_in  in  N_REQ*DATA_W  head packets, channel i at bits [i*DATA_W +: DATA_W].
- gnt  out  N_REQ  one-hot pop strobe to the granted input channel, one cycle wide.
- ri  in  1  downstream ready-in (neighbour can accept).
- so  out  1  send-out to downstream neighbour.
- out_packet  out  DATA_W  packet presented downstream.
- polarity  out  1  router phase; 0 = even VC external, 1 = odd VC external.

Behaviour:
- Reset (reset=0, async):
  - polarity=0, gnt=0, so=0, out_packet=0.
  - Both VC buffers empty, both round-robin pointers=0.
  - Applied mid-transfer, the buffered packet is discarded and is not re-sent.
- Polarity: register toggles every clk edge after reset release: 0,1,0,1,...
- External phase, each cycle:
  - VC v = polarity is external; VC ~polarity is internal.
  - so = full[polarity] & ri, combinational from registers and `ri`.
  - out_packet = buf[polarity] while full[polarity]=1, else 0.
  - Clock edge with so=1: full[polarity] clears; the packet is delivered exactly once.
  - full[polarity]=1 & ri=0: packet held. It retries on the next cycle with the same polarity (2 cycles later); no data loss.
- Internal phase, same cycle:
  - Eligible set E = { i : req[i]=1 and req_vc[i]=~polarity }.
  - If full[~polarity]=0 and E non-empty: grant the first i in E scanning from ptr[~polarity] upward modulo N_REQ.
  - gnt[i]=1 combinationally that cycle. On the edge: buf[~polarity] <= pkt_in[i], full[~polarity] <= 1, ptr[~polarity] <= (i+1) mod N_REQ.
  - If full[~polarity]=1 or E empty: gnt=0 and the pointer is unchanged.
- No simultaneous fill and drain of the same buffer: fill targets the internal VC, drain targets the external VC. Both may occur in the same cycle on different VCs.
- Latency:
  - Packet granted at cycle t is presented at cycle t+1 (polarity flipped) when ri=1.
  - Minimum req-to-so = 1 cycle; throughput ≤ 1 packet/cycle combined, 1 packet per 2 cycles per VC.
- Fairness: per-VC pointers are independent. With all 5 channels continuously requesting one VC, each is granted once per 5 grants on that VC.
- Requests with req_vc=polarity are ignored that cycle and are not lost; the requester holds req.
- gnt is always 0 or one-hot, and never asserts for a channel with req=0.
- Packet contents are not inspected other than via req_vc; width passes through unmodified.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles, release.
  - During reset: polarity=0, so=0, gnt=0, out_packet=0.
  - After release: polarity toggles each cycle.
- Single packet:
  - Stimulus: at a polarity=0 cycle, req=5'b00100, req_vc[2]=1, pkt_in[2]=64'hA5A5_0000_0000_0001, ri=1.
  - Response: gnt=5'b00100 that cycle; next cycle polarity=1, so=1, out_packet=64'hA5A5_0000_0000_0001; following odd cycle so=0.
- Round-robin:
  - Stimulus: all 5 channels request VC1 continuously with distinct packets, ri=1.
  - Response: grants on successive polarity=0 cycles go to channels 0,1,2,3,4,0,...; outputs appear in the same order.
- Backpressure:
  - Stimulus: buffer VC1 full, ri=0 for 4 cycles.
  - Response: so=0; no further VC1 gnt; out_packet stable. After ri=1 at the next polarity=1 cycle, so=1 once with the held packet.
- VC mismatch and mixed traffic:
  - Stimulus: req_vc=0 on ch1 and req_vc=1 on ch3, both held.
  - Response: ch3 granted in the polarity=0 cycle, ch1 in the polarity=1 cycle; both delivered once, interleaved by phase.
- Reset mid-operation:
  - Stimulus: assert reset while VC0 buffer is full.
  - Response: so=0 immediately (async); after release the packet is never emitted and pointers are 0.

Source files
------------

// File: rtl/noc_outport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_outport_arbiter
// Brief    : Mesh-router output-port controller. Owns the even/odd phase,
//            round-robin arbitrates input heads into one buffer per VC, and
//            drains the external-VC buffer over the so/ri link.
// Revision : 1.0 - initial release
// ============================================================================
module noc_outport_arbiter #(
    parameter int DATA_W = 64,
    parameter int N_REQ  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_vc,
    input  logic [N_REQ*DATA_W-1:0] pkt_in,
    output logic [N_REQ-1:0]        gnt,
    input  logic                    ri,
    output logic                    so,
    output logic [DATA_W-1:0]       out_packet,
    output logic                    polarity
);

    localparam int C_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic                r_polarity;
    logic [1:0]          r_full;
    logic [DATA_W-1:0]   r_buf [2];
    logic [C_PTR_W-1:0]  r_ptr [2];

    logic                w_ext;
    logic                w_int;
    logic [N_REQ-1:0]    w_eligible;
    logic                w_found;
    logic [C_PTR_W-1:0]  w_gnt_idx;
    logic [C_PTR_W-1:0]  w_ptr_nxt;
    logic [N_REQ-1:0]    w_gnt;
    logic [DATA_W-1:0]   w_sel_pkt;
    int                  w_scan;

    // The external VC drains downstream while the opposite VC is refilled.
    assign w_ext = r_polarity;
    assign w_int = ~r_polarity;

    assign w_eligible = req & (w_int ? req_vc : ~req_vc);

    // Round-robin scan starting at the internal VC's pointer, wrapping at N_REQ.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = 0;
        if (reset && !r_full[w_int]) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_scan = int'(r_ptr[w_int]) + k;
                if (w_scan >= N_REQ) begin
                    w_scan = w_scan - N_REQ;
                end
                if (!w_found && w_eligible[w_scan]) begin
                    w_found   = 1'b1;
                    w_gnt_idx = C_PTR_W'(w_scan);
                end
            end
        end
    end

    always_comb begin
        w_gnt     = '0;
        w_sel_pkt = '0;
        if (w_found) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_pkt = pkt_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == C_PTR_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_polarity <= 1'b0;
            r_full     <= 2'b00;
            for (int v = 0; v < 2; v++) begin
                r_buf[v] <= '0;
                r_ptr[v] <= '0;
            end
        end else begin
            r_polarity <= ~r_polarity;
            if (so) begin
                r_full[w_ext] <= 1'b0;
            end
            if (w_found) begin
                r_full[w_int] <= 1'b1;
                r_buf[w_int]  <= w_sel_pkt;
                r_ptr[w_int]  <= w_ptr_nxt;
            end
        end
    end

    assign gnt        = w_gnt;
    assign so         = r_full[w_ext] & ri;
    assign out_packet = r_full[w_ext] ? r_buf[w_ext] : '0;
    assign polarity   = r_polarity;

endmodule
`default_nettype wire

// File: tb/tb_noc_outport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_outport_arbiter
// Brief    : Directed bench for noc_outport_arbiter with a scoreboard queue of
//            expected downstream packets popped by an so monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_outport_arbiter;

    localparam int DATA_W = 64;
    localparam int N_REQ  = 5;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_vc;
    logic [N_REQ*DATA_W-1:0] pkt_in;
    logic [N_REQ-1:0]        gnt;
    logic                    ri;
    logic                    so;
    logic [DATA_W-1:0]       out_packet;
    logic                    polarity;

    logic [DATA_W-1:0] pkts [N_REQ];
    logic [DATA_W-1:0] sb [$];
    logic              exp_pol;
    logic [DATA_W-1:0] held;
    int                tests;
    int                fails;

    noc_outport_arbiter #(.DATA_W(DATA_W), .N_REQ(N_REQ)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req        (req),
        .req_vc     (req_vc),
        .pkt_in     (pkt_in),
        .gnt        (gnt),
        .ri         (ri),
        .so         (so),
        .out_packet (out_packet),
        .polarity   (polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            pkt_in[i*DATA_W +: DATA_W] = pkts[i];
        end
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every so pulse must match the oldest granted packet.
    always @(negedge clk) begin
        if (so === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_so: got so=1 out_packet=%h, required no output", out_packet);
            end else begin
                chk("out_packet", out_packet, sb.pop_front());
            end
        end
    end

    // One cycle: check phase/gnt/so mid-cycle, log the grant, then cross the edge.
    task automatic step(input logic [N_REQ-1:0] eg, input logic es, input bit push = 1'b1);
        int ch;
        ch = -1;
        #3;
        chk("polarity", 64'(polarity), 64'(exp_pol));
        chk("gnt", 64'(gnt), 64'(eg));
        chk("so", 64'(so), 64'(es));
        for (int i = 0; i < N_REQ; i++) begin
            if (eg[i]) ch = i;
        end
        if (ch >= 0 && push) sb.push_back(pkts[ch]);
        @(posedge clk);
        if (rst_n) exp_pol = ~exp_pol;
        #1;
        if (ch >= 0) pkts[ch] = pkts[ch] + 64'h1_0000;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        exp_pol = 1'b0;
        req     = '0;
        req_vc  = '0;
        ri      = 1'b0;
        repeat (2) step('0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic align0();
        if (exp_pol) step('0, 1'b0);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        req     = '0;
        req_vc  = '0;
        ri      = 1'b0;
        exp_pol = 1'b0;
        for (int i = 0; i < N_REQ; i++) pkts[i] = {16'hC0DE, 16'(i), 32'h0};
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;

        // Reset and idle
        req = 5'b11111;
        req_vc = 5'b01010;
        for (int c = 0; c < 3; c++) begin
            chk("reset_out_packet", out_packet, 64'h0);
            step('0, 1'b0);
        end
        req = '0;
        req_vc = '0;
        rst_n = 1'b1;
        repeat (4) step('0, 1'b0);

        // Single packet
        align0();
        ri = 1'b1;
        pkts[2] = 64'hA5A5_0000_0000_0001;
        req = 5'b00100;
        req_vc = 5'b00100;
        step(5'b00100, 1'b0);
        req = '0;
        step('0, 1'b1);
        step('0, 1'b0);
        step('0, 1'b0);

        // Round-robin on VC1
        do_reset();
        ri = 1'b1;
        req = 5'b11111;
        req_vc = 5'b11111;
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) step(5'(1 << ((k / 2) % 5)), 1'b0);
            else            step('0, 1'b1);
        end
        req = '0;
        step('0, 1'b0);
        step('0, 1'b0);

        // Backpressure on VC1
        do_reset();
        ri = 1'b0;
        req = 5'b00001;
        req_vc = 5'b00001;
        held = pkts[0];
        step(5'b00001, 1'b0);
        for (int c = 0; c < 4; c++) begin
            chk("held_packet", out_packet, (c % 2 == 0) ? held : 64'h0);
            step('0, 1'b0);
        end
        ri = 1'b1;
        step('0, 1'b1);
        step(5'b00001, 1'b0);
        req = '0;
        step('0, 1'b1);
        step('0, 1'b0);

        // VC mismatch / mixed traffic
        do_reset();
        ri = 1'b1;
        req = 5'b01010;
        req_vc = 5'b01000;
        step(5'b01000, 1'b0);
        req[3] = 1'b0;
        step(5'b00010, 1'b1);
        req = '0;
        step('0, 1'b1);
        step('0, 1'b0);

        // Reset mid-operation with VC0 full
        do_reset();
        step('0, 1'b0);
        req = 5'b00001;
        req_vc = 5'b00000;
        held = pkts[0];
        step(5'b00001, 1'b0, 1'b0);
        req = '0;
        ri = 1'b1;
        #1;
        chk("pre_reset_so", 64'(so), 64'h1);
        chk("pre_reset_packet", out_packet, held);
        rst_n = 1'b0;
        exp_pol = 1'b0;
        #1;
        chk("async_so", 64'(so), 64'h0);
        chk("async_packet", out_packet, 64'h0);
        chk("async_polarity", 64'(polarity), 64'h0);
        step('0, 1'b0);
        step('0, 1'b0);
        rst_n = 1'b1;
        repeat (4) step('0, 1'b0);
        req = 5'b11111;
        req_vc = 5'b11111;
        step(5'b00001, 1'b0);
        req_vc = 5'b00000;
        step(5'b00001, 1'b1);
        req = '0;
        step('0, 1'b1);
        step('0, 1'b0);

        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
